// File: rtl/receive_all_if.sv
// Request/Ack handshake bus between the sending board and receive_all.
// master = sender side, slave = receiver side.
interface receive_all_if;
    logic       Request_in;
    logic [5:0] inter_data_in;
    logic       Ack_out;

    modport master (output Request_in, output inter_data_in, input Ack_out);
    modport slave  (input Request_in, input inter_data_in, output Ack_out);
endinterface

// File: rtl/receive_all.sv
// Interboard receiver: 4-phase Request/Ack on a 6-bit bus, collects six words per message,
// recognises the reserved reset word and aborts stalled transfers with a watchdog.
module receive_all #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic          clk,
    input  logic          rst,
    receive_all_if.slave  bus,
    output logic          recv_valid,
    output logic [3:0]    recv_msg_type,
    output logic [4:0]    recv_block_x,
    output logic [2:0]    recv_block_y,
    output logic [5:0]    recv_card,
    output logic [2:0]    recv_sel_len,
    output logic          recv_move_dir,
    output logic          interboard_rst_out,
    output logic          rx_error,
    output logic          busy
);
    localparam int             WDW     = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
    localparam logic [5:0]     RST_WORD = 6'h3F;

    typedef enum logic {WAIT_REQ_UP, WAIT_REQ_DOWN} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    state_t                 state_q, state_d;
    logic [2:0]             idx_q, idx_d;
    logic [5:0][5:0]        shadow_q, shadow_d;
    logic [WDW-1:0]         wd_q, wd_d;
    logic                   ack_q;
    logic                   valid_q, valid_d;
    logic                   rstw_q, rstw_d;
    logic                   err_q, err_d;
    logic [3:0]             msg_type_q;
    logic [4:0]             block_x_q;
    logic [2:0]             block_y_q;
    logic [5:0]             card_q;
    logic [2:0]             sel_len_q;
    logic                   move_dir_q;

    assign req_s = sync_q[SYNC_STAGES-1];
    assign busy  = (idx_q != 3'd0) || (state_q == WAIT_REQ_DOWN);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        valid_d  = 1'b0;
        rstw_d   = 1'b0;
        err_d    = 1'b0;
        wd_d     = '0;
        case (state_q)
            WAIT_REQ_UP: begin
                if (req_s) begin
                    shadow_d[idx_q] = bus.inter_data_in;
                    state_d         = WAIT_REQ_DOWN;
                end
            end
            WAIT_REQ_DOWN: begin
                if (!req_s) begin
                    state_d = WAIT_REQ_UP;
                    if (idx_q == 3'd0 && shadow_q[0] == RST_WORD) begin
                        rstw_d = 1'b1;
                    end else if (idx_q == 3'd5) begin
                        idx_d   = 3'd0;
                        valid_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
        endcase
        // A handshake transition in the expiry cycle wins; the count only runs while stalled.
        if (state_d == state_q && busy) begin
            if (wd_q == WD_LAST) begin
                state_d = WAIT_REQ_UP;
                idx_d   = 3'd0;
                err_d   = 1'b1;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q     <= '0;
            state_q    <= WAIT_REQ_UP;
            idx_q      <= 3'd0;
            shadow_q   <= '0;
            wd_q       <= '0;
            ack_q      <= 1'b0;
            valid_q    <= 1'b0;
            rstw_q     <= 1'b0;
            err_q      <= 1'b0;
            msg_type_q <= '0;
            block_x_q  <= '0;
            block_y_q  <= '0;
            card_q     <= '0;
            sel_len_q  <= '0;
            move_dir_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], bus.Request_in};
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            wd_q     <= wd_d;
            ack_q    <= (state_d == WAIT_REQ_DOWN);
            valid_q  <= valid_d;
            rstw_q   <= rstw_d;
            err_q    <= err_d;
            if (valid_d) begin
                msg_type_q <= shadow_q[0][3:0];
                block_x_q  <= shadow_q[1][4:0];
                block_y_q  <= shadow_q[2][2:0];
                card_q     <= shadow_q[3];
                sel_len_q  <= shadow_q[4][2:0];
                move_dir_q <= shadow_q[5][0];
            end
        end
    end

    assign bus.Ack_out        = ack_q;
    assign recv_valid         = valid_q;
    assign interboard_rst_out = rstw_q;
    assign rx_error           = err_q;
    assign recv_msg_type      = msg_type_q;
    assign recv_block_x       = block_x_q;
    assign recv_block_y       = block_y_q;
    assign recv_card          = card_q;
    assign recv_sel_len       = sel_len_q;
    assign recv_move_dir      = move_dir_q;
endmodule
